// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared width, iteration count and FSM encoding for div32_iter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int XLEN     = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div32_negate.sv
// ============================================================================
// Module      : div32_negate
// Description : Conditional two's-complement of an XLEN-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32_negate #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_val,
  input  logic            i_neg,
  output logic [XLEN-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + {{(XLEN-1){1'b0}}, 1'b1}) : i_val;

endmodule

`default_nettype wire

// File: rtl/div32_iter.sv
// ============================================================================
// Module      : div32_iter
// Description : Iterative 32-bit restoring divider (DIV/DIVU), 34-cycle latency.
//               Optional DIV_EARLY_OUT_EN shortcuts |divisor| > |dividend|.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32_iter #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r,
  output logic            div_zero
);

  import div_pkg::*;

  div_state_e        r_state;
  div_state_e        w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvsr;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic              r_done;

  logic [XLEN-1:0]   w_dvnd_abs;
  logic [XLEN-1:0]   w_dvsr_abs;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_start_ok;
  logic              w_zero;
  logic              w_early;

  div32_negate #(.XLEN(XLEN)) u_abs_dvnd (
    .i_val (dividend),
    .i_neg (is_signed & dividend[XLEN-1]),
    .o_val (w_dvnd_abs)
  );

  div32_negate #(.XLEN(XLEN)) u_abs_dvsr (
    .i_val (divisor),
    .i_neg (is_signed & divisor[XLEN-1]),
    .o_val (w_dvsr_abs)
  );

  div32_negate #(.XLEN(XLEN)) u_fix_q (
    .i_val (r_quo),
    .i_neg (r_neg_q),
    .o_val (w_q_fix)
  );

  div32_negate #(.XLEN(XLEN)) u_fix_r (
    .i_val (r_rem),
    .i_neg (r_neg_r),
    .o_val (w_r_fix)
  );

  assign w_start_ok = start & ~cancel;
  assign w_zero     = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = ~w_zero & (w_dvsr_abs > w_dvnd_abs);
`else
  assign w_early = 1'b0;
`endif

  // Partial remainder shifted left with the next dividend bit pulled in
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next_state = (w_zero || w_early) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(ITER_CNT - 1)) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (cancel && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_cnt   <= '0;
            r_dvsr  <= w_dvsr_abs;
            r_neg_r <= is_signed & dividend[XLEN-1];
            r_dz    <= w_zero;
            // Shortcut paths preload the final magnitudes and go straight to FIX
            if (w_zero) begin
              r_quo   <= '1;
              r_rem   <= w_dvnd_abs;
              r_neg_q <= 1'b0;
            end else if (w_early) begin
              r_quo   <= '0;
              r_rem   <= w_dvnd_abs;
              r_neg_q <= 1'b0;
            end else begin
              r_quo   <= w_dvnd_abs;
              r_rem   <= '0;
              r_neg_q <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: begin
          r_quo <= w_q_fix;
          r_rem <= w_r_fix;
        end
        S_DONE: begin
          if (!cancel) begin
            q        <= r_quo;
            r        <= r_rem;
            div_zero <= r_dz;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div32_iter.sv
// ============================================================================
// Module      : tb_div32_iter
// Description : Self-checking bench for div32_iter against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div32_iter;

  localparam int XLEN = 32;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b1;
  logic            start     = 1'b0;
  logic            is_signed = 1'b0;
  logic            cancel    = 1'b0;
  logic [XLEN-1:0] dividend  = '0;
  logic [XLEN-1:0] divisor   = '0;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;
  bit chk_en  = 1'b0;

  div32_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Architectural DIV/DIVU result, straight from the arithmetic rules
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] rq, output logic [31:0] rr);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      rq = 32'hFFFF_FFFF;
      rr = a;
    end else if (!s) begin
      rq = a / b;
      rr = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      rq = 32'h8000_0000;
      rr = 32'd0;
    end else begin
      rq = sa / sb;
      rr = sa % sb;
    end
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (s && a[31]) ? (32'd0 - a) : a;
    mb = (s && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mb > ma) return 2;
`else
    if (mb > ma && ma == 32'hFFFF_FFFF) return 34;
`endif
    return 34;
  endfunction

  // Behavioural model: a countdown to completion, not a state machine
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_q    = '0;
  logic [31:0] m_r    = '0;
  logic [31:0] p_q    = '0;
  logic [31:0] p_r    = '0;
  logic        p_dz   = 1'b0;
  int          m_left = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (cancel) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_done = 1'b1;
            m_q = p_q; m_r = p_r; m_dz = p_dz;
          end
        end
      end else if (start && !cancel) begin
        ref_div(dividend, divisor, is_signed, p_q, p_r);
        p_dz   = (divisor == 32'd0);
        m_left = ref_lat(dividend, divisor, is_signed);
        m_busy = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done) n_done++;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("q", q, m_q);
      check("r", r, m_r);
      check("div_zero", 32'(div_zero), 32'(m_dz));
    end
  end

  // Called at a negedge; leaves at the negedge of the done cycle (or timeout)
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input bit poke, input string tag);
    int n;
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin
        start = 1'b1; dividend = 32'd7; divisor = 32'd3; is_signed = 1'b0;
      end
      if (poke && n == 6) start = 1'b0;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_dz"}, 32'(div_zero), 32'(edz));
  endtask

  logic [31:0] eq;
  logic [31:0] er;

  initial begin
    int dn;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);

    // Pin the model with hand-computed results
    ref_div(32'd100, 32'd7, 1'b0, eq, er);
    check("model_u100_7_q", eq, 32'd14);
    check("model_u100_7_r", er, 32'd2);
    ref_div(32'hFFFF_FF9C, 32'd7, 1'b1, eq, er);
    check("model_s-100_7_q", eq, 32'hFFFF_FFF2);
    check("model_s-100_7_r", er, 32'hFFFF_FFFE);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, eq, er);
    check("model_ovf_q", eq, 32'h8000_0000);

    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, 1'b0, "u100_7");
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, "s-100_7");
    run_op(32'd5, 32'd0, 1'b0, 2, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, "div0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 32'h8000_0000, 32'd0, 1'b0, 1'b1, "ovf");

    // Cancel: raised after edge 10, sampled at edge 11
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    dn = n_done;
    repeat (30) @(negedge clk);
    check("cancel_nodone", n_done, dn);
    check("cancel_q", q, 32'h8000_0000);
    check("cancel_r", r, 32'd0);

    // Asynchronous reset in the middle of an operation
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_q", q, 32'd0);
    check("arst_r", r, 32'd0);
    check("arst_dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd1000, 32'd33, 1'b0, 34, 32'd30, 32'd10, 1'b0, 1'b0, "post_rst");

    // Randomised traffic, model-checked every cycle
    dn = n_done;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start     = ($urandom % 4) == 0;
      cancel    = ($urandom % 100) == 0;
      is_signed = 1'($urandom);
      case ($urandom % 8)
        0: begin dividend = $urandom; divisor = 32'd0; end
        1: begin dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF; end
        2: begin dividend = $urandom; divisor = $urandom % 16; end
        3: begin dividend = $urandom % 1000; divisor = $urandom; end
        default: begin dividend = $urandom; divisor = $urandom; end
      endcase
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", 32'(busy), 32'd0);
    check("rand_progress", 32'(n_done - dn > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
